// File: rtl/act2_result_classifier_if.sv
// Layer-2 activation result bus: operand capture inputs plus the valid/ready decision output.
interface act2_result_classifier_if;
  localparam int unsigned DW = 64;

  logic [DW-1:0] act_out1;
  logic [DW-1:0] act_out2;
  logic          done_act_2;
  logic          out_valid;
  logic          out_ready;
  logic          out_class;
  logic          out_nan;
  logic [DW-1:0] out_value;

  modport slave (
    input  act_out1, act_out2, done_act_2, out_ready,
    output out_valid, out_class, out_nan, out_value
  );

  modport master (
    output act_out1, act_out2, done_act_2, out_ready,
    input  out_valid, out_class, out_nan, out_value
  );
endinterface

// File: rtl/act2_result_classifier.sv
// Captures the two output-neuron doubles, picks the winning class on raw IEEE-754 bit
// patterns and queues decisions in a show-ahead FIFO toward the result reporter.
module act2_result_classifier #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2,
  parameter int unsigned DROPW = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  act2_result_classifier_if.slave  act_bus,
  output logic                     overflow,
  output logic [DROPW-1:0]         drop_count,
  output logic                     busy
);
  localparam int unsigned DW = 64;
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic          cls;
    logic          nan;
    logic [DW-1:0] value;
  } decision_t;

  logic [DW-1:0]    r_a1;
  logic [DW-1:0]    r_a2;
  logic             r_s1_valid;
  decision_t        r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_overflow;
  logic [DROPW-1:0] r_drop_count;

  logic             w_nan1;
  logic             w_nan2;
  logic             w_both_zero;
  logic             w_a2_gt;
  decision_t        w_dec;
  decision_t        w_head;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [CW-1:0]    w_count_nxt;

  // Ordering on sign/magnitude fields; +0 and -0 are equal, NaN forces class 0.
  always_comb begin
    w_nan1      = (&r_a1[62:52]) && (|r_a1[51:0]);
    w_nan2      = (&r_a2[62:52]) && (|r_a2[51:0]);
    w_both_zero = (r_a1[62:0] == 63'd0) && (r_a2[62:0] == 63'd0);
    w_a2_gt     = 1'b0;
    unique case ({r_a2[63], r_a1[63]})
      2'b00:   w_a2_gt = r_a2[62:0] > r_a1[62:0];
      2'b01:   w_a2_gt = !w_both_zero;
      2'b10:   w_a2_gt = 1'b0;
      default: w_a2_gt = r_a2[62:0] < r_a1[62:0];
    endcase
    w_dec.nan   = w_nan1 || w_nan2;
    w_dec.cls   = !w_dec.nan && w_a2_gt;
    w_dec.value = w_dec.cls ? r_a2 : r_a1;
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    w_full      = (r_count == CW'(DEPTH));
    w_pop       = r_out_valid && act_bus.out_ready;
    w_push      = r_s1_valid && (!w_full || w_pop);
    w_drop      = r_s1_valid && w_full && !w_pop;
    w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    w_head      = r_mem[r_rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a1         <= '0;
      r_a2         <= '0;
      r_s1_valid   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_s1_valid <= act_bus.done_act_2;
      if (act_bus.done_act_2) begin
        r_a1 <= act_bus.act_out1;
        r_a2 <= act_bus.act_out2;
      end
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_dec;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count     <= w_count_nxt;
      r_out_valid <= (w_count_nxt != '0);
      r_busy      <= act_bus.done_act_2 || (w_count_nxt != '0);
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != '1) r_drop_count <= r_drop_count + DROPW'(1);
      end
    end
  end

  assign act_bus.out_valid = r_out_valid;
  assign act_bus.out_class = w_head.cls;
  assign act_bus.out_nan   = w_head.nan;
  assign act_bus.out_value = w_head.value;
  assign overflow          = r_overflow;
  assign drop_count        = r_drop_count;
  assign busy              = r_busy;
endmodule
